// File: rtl/ahb_master.sv
// Single-outstanding AHB-Lite master: turns a local req/ack handshake into one
// SINGLE NONSEQ transfer and reports completion with a one-cycle response pulse.
module ahb_master (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        req,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wd,
    input  logic [2:0]  req_size,
    output logic        req_ack,
    output logic        resp_valid,
    output logic [31:0] resp_rd,
    output logic        resp_err,
    output logic [31:0] haddr,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    output logic        hwrite,
    output logic [1:0]  htrans,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    input  logic [1:0]  hresp,
    input  logic        hready
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    state_e      state_q, state_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [2:0]  size_q;
    logic [2:0]  size_d;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rd_q;
    logic        done;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_ack = 1'b0;
        htrans  = TransIdle;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Gate with reset so a held req cannot ack while the block is in reset.
                if (req && hresetn) begin
                    req_ack = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                htrans = TransNonseq;
                if (hready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (hready) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sizes above a word are not supported on this 32-bit bus; issue them as a word.
    assign size_d = (req_size > 3'd2) ? 3'd2 : req_size;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wd_q         <= 32'h0;
            size_q       <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rd_q    <= 32'h0;
        end else begin
            resp_valid_q <= done;
            if (req_ack) begin
                we_q   <= req_we;
                addr_q <= req_addr;
                wd_q   <= req_wd;
                size_q <= size_d;
            end
            if (done) begin
                resp_err_q <= (hresp != 2'b00);
                if (!we_q) begin
                    resp_rd_q <= hrdata;
                end
            end
        end
    end

    assign haddr      = addr_q;
    assign hwdata     = wd_q;
    assign hwrite     = we_q;
    assign hsize      = size_q;
    assign hburst     = 3'b000;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rd    = resp_rd_q;

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: stimulus pushes expected responses, a monitor
// pops and checks them (data, error flag and arrival cycle) on every resp_valid.
module tb_ahb_master;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        req;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wd;
    logic [2:0]  req_size;
    logic        req_ack;
    logic        resp_valid;
    logic [31:0] resp_rd;
    logic        resp_err;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  hresp;
    logic        hready;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    ahb_master dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wd    (req_wd),
        .req_size  (req_size),
        .req_ack   (req_ack),
        .resp_valid(resp_valid),
        .resp_rd   (resp_rd),
        .resp_err  (resp_err),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hsize     (hsize),
        .hburst    (hburst),
        .hresp     (hresp),
        .hready    (hready)
    );

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] rd, input logic err, input int c);
        exp_t x;
        x.rd  = rd;
        x.err = err;
        x.cyc = c;
        q.push_back(x);
    endtask

    task automatic step();
        @(negedge hclk);
    endtask

    // Monitor: every response must match the head of the scoreboard at the expected cycle.
    always @(negedge hclk) begin
        if (hresetn && resp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_rd", resp_rd, e.rd);
                chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
            end
        end
        if (q.size() > 0 && cyc > q[0].cyc) begin
            checks++;
            errors++;
            $display("FAIL late_resp: got no resp_valid, expected one at cycle %0d", q[0].cyc);
            e = q.pop_front();
        end
    end

    initial begin
        req = 0; req_we = 0; req_addr = 0; req_wd = 0; req_size = 0;
        hrdata = 0; hresp = 2'b00; hready = 1; hresetn = 0;

        // Reset state, with req held high to prove it is ignored
        step(); req = 1; #1;
        chk("rst_htrans", {30'h0, htrans}, 32'h0);
        chk("rst_hwrite", {31'h0, hwrite}, 32'h0);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_hsize", {29'h0, hsize}, 32'h0);
        chk("rst_req_ack", {31'h0, req_ack}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_resp_rd", resp_rd, 32'h0);
        chk("rst_hburst", {29'h0, hburst}, 32'h0);
        step(); req = 0; hresetn = 1;
        step();

        // T1: zero-wait word write
        req = 1; req_we = 1; req_addr = 32'h10; req_wd = 32'hA5A5A5A5; req_size = 3'd2; #1;
        chk("t1_ack", {31'h0, req_ack}, 32'h1);
        push(32'h0, 1'b0, cyc + 3);
        step(); req = 0; #1;
        chk("t1_htrans", {30'h0, htrans}, 32'h2);
        chk("t1_haddr", haddr, 32'h10);
        chk("t1_hwrite", {31'h0, hwrite}, 32'h1);
        chk("t1_hsize", {29'h0, hsize}, 32'h2);
        chk("t1_no_ack", {31'h0, req_ack}, 32'h0);
        step(); #1;
        chk("t1_data_htrans", {30'h0, htrans}, 32'h0);
        chk("t1_hwdata", hwdata, 32'hA5A5A5A5);
        chk("t1_data_haddr", haddr, 32'h10);
        step(); step();

        // T2: halfword read with two data-phase wait states
        req = 1; req_we = 0; req_addr = 32'h20; req_size = 3'd1; #1;
        chk("t2_ack", {31'h0, req_ack}, 32'h1);
        push(32'h12345678, 1'b0, cyc + 5);
        step(); req = 0; #1;
        chk("t2_htrans", {30'h0, htrans}, 32'h2);
        chk("t2_hwrite", {31'h0, hwrite}, 32'h0);
        chk("t2_hsize", {29'h0, hsize}, 32'h1);
        step(); hready = 0; #1;
        chk("t2_data_htrans", {30'h0, htrans}, 32'h0);
        step();
        step(); hready = 1; hrdata = 32'h12345678;
        step(); hrdata = 32'h0;
        step();

        // T3: write with size 7 and three address-phase wait states; resp_rd must not change
        req = 1; req_we = 1; req_addr = 32'h44; req_wd = 32'h0; req_size = 3'd7; #1;
        push(32'h12345678, 1'b0, cyc + 6);
        step(); req = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            hready = (i == 3); #1;
            chk("t3_htrans", {30'h0, htrans}, 32'h2);
            chk("t3_haddr", haddr, 32'h44);
            chk("t3_hwrite", {31'h0, hwrite}, 32'h1);
            chk("t3_hsize", {29'h0, hsize}, 32'h2);
        end
        step(); step(); step();

        // T4: two-cycle ERROR response
        hrdata = 32'hDEADBEEF;
        req = 1; req_we = 0; req_addr = 32'h80; req_size = 3'd2; #1;
        push(32'hDEADBEEF, 1'b1, cyc + 4);
        step(); req = 0; hready = 1;
        step(); hready = 0; hresp = 2'b01; #1;
        chk("t4_data_htrans", {30'h0, htrans}, 32'h0);
        step(); hready = 1;
        step(); hresp = 2'b00; #1;
        chk("t4_idle_htrans", {30'h0, htrans}, 32'h0);
        step();

        // T5: back-to-back reads with req held; second gets hresp=10 (treated as ERROR)
        req = 1; req_we = 0; req_addr = 32'h100; req_size = 3'd0; hrdata = 32'h11111111; #1;
        chk("t5_ack1", {31'h0, req_ack}, 32'h1);
        push(32'h11111111, 1'b0, cyc + 3);
        step(); #1;
        chk("t5_ignored_addr", {31'h0, req_ack}, 32'h0);
        chk("t5_htrans1", {30'h0, htrans}, 32'h2);
        chk("t5_haddr1", haddr, 32'h100);
        chk("t5_hsize1", {29'h0, hsize}, 32'h0);
        step(); #1;
        chk("t5_ignored_data", {31'h0, req_ack}, 32'h0);
        step(); req_addr = 32'h104; hrdata = 32'h22222222; hresp = 2'b10; #1;
        chk("t5_ack2", {31'h0, req_ack}, 32'h1);
        chk("t5_ack2_with_resp", {31'h0, resp_valid}, 32'h1);
        push(32'h22222222, 1'b1, cyc + 3);
        step(); req = 0; #1;
        chk("t5_htrans2", {30'h0, htrans}, 32'h2);
        chk("t5_haddr2", haddr, 32'h104);
        step(); step(); hresp = 2'b00;
        step();

        // T6: reset during the data phase aborts the transfer
        req = 1; req_we = 1; req_addr = 32'h200; req_wd = 32'h5; req_size = 3'd2; #1;
        chk("t6_ack", {31'h0, req_ack}, 32'h1);
        step(); req = 0; hready = 1;
        step(); hready = 0; #1;
        chk("t6_hwdata", hwdata, 32'h5);
        #2 hresetn = 0; #1;
        chk("t6_rst_htrans", {30'h0, htrans}, 32'h0);
        chk("t6_rst_haddr", haddr, 32'h0);
        chk("t6_rst_hwdata", hwdata, 32'h0);
        chk("t6_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        step(); hresetn = 1; hready = 1; #1;
        chk("t6_post_htrans", {30'h0, htrans}, 32'h0);
        repeat (5) step();

        chk("queue_empty", q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
